// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: valid/ready requests, a fixed
// wait of LATENCY cycles, then a load-data or store-ack response with an error flag.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            commitErr;
  logic [IdxW-1:0] idx;

  assign accept    = (state_q == IDLE) && req_valid;
  assign commit    = (state_q == WAIT) && (cnt_q == 4'd0);
  // Upper address bits only feed the range check; no wrap-around into the array.
  assign commitErr = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign idx       = addr_q[IdxW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d = 4'(LATENCY);
    end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit) begin
      err_d   = commitErr;
      rdata_d = (commitErr || write_q) ? 32'd0 : mem[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // The array has no reset so a reset after commit keeps the stored word.
  always_ff @(posedge clk) begin
    if (commit && write_q && !commitErr) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
